// File: rtl/nmosfet_model.sv
// rtl/nmosfet_model.sv - clocked square-law NMOS drain-current model on millivolt buses
module nmosfet_model #(
    parameter int V_W    = 12,
    parameter int VTH_MV = 400,
    parameter int K_UA   = 200,
    parameter int ID_W   = 41
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [V_W-1:0]         vd,
    input  logic [V_W-1:0]         vg,
    input  logic [V_W-1:0]         vs,
    output logic                   out_valid,
    output logic signed [ID_W-1:0] id,
    output logic [1:0]             region
);

    localparam int SW  = V_W + 2;
    localparam int PSW = 2 * V_W + 2;
    localparam int MW  = 2 * V_W + 18;

    localparam logic signed [SW-1:0] VTH_S = SW'(VTH_MV);
    localparam logic signed [MW-1:0] K_S   = MW'(K_UA);

    logic                   swap;
    logic [V_W-1:0]         drain;
    logic [V_W-1:0]         source;
    logic signed [SW-1:0]   vgs;
    logic signed [SW-1:0]   vds;
    logic signed [SW-1:0]   vov;
    logic signed [PSW-1:0]  vov_x;
    logic signed [PSW-1:0]  vds_x;
    logic signed [PSW-1:0]  poly;
    logic signed [MW-1:0]   prod;
    logic signed [ID_W-1:0] mag;
    logic signed [ID_W-1:0] id_next;
    logic [1:0]             region_next;

    // The device is symmetric: whichever terminal sits higher acts as the drain.
    always_comb begin
        swap   = vd < vs;
        drain  = swap ? vs : vd;
        source = swap ? vd : vs;
        vgs    = $signed({2'b00, vg}) - $signed({2'b00, source});
        vds    = $signed({2'b00, drain}) - $signed({2'b00, source});
        vov    = vgs - VTH_S;
        vov_x  = PSW'(vov);
        vds_x  = PSW'(vds);
    end

    // Triode uses vds*(2*vov - vds), which equals 2*vov*vds - vds^2 and stays non-negative.
    always_comb begin
        poly        = '0;
        region_next = 2'd0;
        if (vov > 0) begin
            if (vds < vov) begin
                poly        = vds_x * ((vov_x <<< 1) - vds_x);
                region_next = 2'd1;
            end else begin
                poly        = vov_x * vov_x;
                region_next = 2'd2;
            end
        end
        prod    = K_S * MW'(poly);
        mag     = ID_W'(prod >>> 1);
        id_next = swap ? -mag : mag;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            id        <= '0;
            region    <= 2'd0;
        end else if (in_valid) begin
            out_valid <= 1'b1;
            id        <= id_next;
            region    <= region_next;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nmosfet_model.sv
// tb/tb_nmosfet_model.sv - scoreboard bench for nmosfet_model
module tb_nmosfet_model;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic [11:0]        vd = '0;
    logic [11:0]        vg = '0;
    logic [11:0]        vs = '0;
    logic               out_valid;
    logic signed [40:0] id;
    logic [1:0]         region;

    nmosfet_model dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .vd        (vd),
        .vg        (vg),
        .vs        (vs),
        .out_valid (out_valid),
        .id        (id),
        .region    (region)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit     v;
        longint i;
        int     r;
    } exp_t;

    exp_t   sb[$];
    int     total = 0;
    int     bad = 0;
    longint hold_id = 0;
    int     hold_r = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint model(input int d, input int g, input int s, output int r);
        longint dr, sr, vov, vds, mag;
        bit neg;
        neg = d < s;
        dr  = neg ? s : d;
        sr  = neg ? d : s;
        vov = g - sr - 400;
        vds = dr - sr;
        if (vov <= 0) begin
            mag = 0;
            r   = 0;
        end else if (vds < vov) begin
            mag = (200 * (2 * vov * vds - vds * vds)) / 2;
            r   = 1;
        end else begin
            mag = (200 * vov * vov) / 2;
            r   = 2;
        end
        return neg ? -mag : mag;
    endfunction

    task automatic step(input bit r, input bit v, input int d, input int g, input int s);
        exp_t e;
        int   rr;
        rst_n    = r;
        in_valid = v;
        vd       = 12'(d);
        vg       = 12'(g);
        vs       = 12'(s);
        if (!r) begin
            hold_id = 0;
            hold_r  = 0;
            e.v     = 1'b0;
        end else if (v) begin
            hold_id = model(d, g, s, rr);
            hold_r  = rr;
            e.v     = 1'b1;
        end else begin
            e.v = 1'b0;
        end
        e.i = hold_id;
        e.r = hold_r;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq("out_valid", longint'(out_valid), longint'(e.v));
        check_eq("id", longint'(id), e.i);
        check_eq("region", longint'(region), longint'(e.r));
    endtask

    initial begin
        step(0, 1, 1500, 1500, 0);
        step(0, 1, 1500, 1500, 0);
        check_eq("reset_id", longint'(id), 0);
        step(1, 1, 1500, 1500, 0);
        check_eq("release_id", longint'(id), 121000000);

        for (int i = 0; i <= 15; i++) begin
            step(1, 1, 1500, i * 100, 0);
            if (i == 4) check_eq("ramp_vg400", longint'(id), 0);
            if (i == 10) check_eq("ramp_vg1000", longint'(id), 36000000);
            if (i == 15) check_eq("ramp_vg1500", longint'(id), 121000000);
        end
        for (int i = 14; i >= 0; i--) begin
            step(1, 1, 1500, i * 100, 0);
            if (i == 10) check_eq("fall_vg1000", longint'(id), 36000000);
        end

        step(1, 1, 500, 1500, 0);
        check_eq("triode_id", longint'(id), 85000000);
        check_eq("triode_region", longint'(region), 1);
        step(1, 1, 500, 900, 0);
        check_eq("edge_id", longint'(id), 25000000);
        check_eq("edge_region", longint'(region), 2);
        step(1, 1, 0, 1500, 500);
        check_eq("reverse_id", longint'(id), -85000000);
        step(1, 1, 700, 1500, 700);
        check_eq("vds0_region", longint'(region), 1);

        step(1, 1, 1200, 1300, 100);
        for (int i = 0; i < 3; i++) step(1, 0, 100 * i, 2000 + i, 300);
        step(1, 1, 300, 1000, 0);

        step(1, 1, 1, 1500, 0);
        check_eq("odd_id", longint'(id), 219900);
        step(1, 1, 0, 1501, 1);

        step(1, 1, 4095, 4095, 0);
        step(0, 1, 800, 4095, 0);
        step(1, 1, 0, 4095, 4095);
        for (int i = 0; i < 40; i++)
            step(1, 1'($urandom_range(0, 3) != 0), $urandom_range(0, 4095),
                 $urandom_range(0, 4095), $urandom_range(0, 4095));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
